ex_match_unit: RTL and testbench
================================

Name: ex_match_unit

Overview:
- Iterative byte-pattern search unit in the EX stage, alongside the ALU.
- Executes the MATCH operation over multiple cycles, one bit position per cycle, in place of a combinational loop.
- Searches `src2` for the lowest bit offset whose 8-bit window equals `src1[7:0]`.
- Stalls the pipeline while searching, then presents a 32-bit result for the EX result mux.

Parameters:
- `WINDOW`, 8: pattern width in bits, compared against `src1[WINDOW-1:0]`.
- `POSITIONS`, 25: number of offsets searched, 0..POSITIONS-1. Must equal 32-WINDOW+1.
- `NOMATCH_VAL`, 32'hFFFF_FFFF: result value when no offset matches.

Ports:
- `clk`, input, 1: clock.
- `resetn`, input, 1: reset, asynchronous, active-low.
- `flush`, input, 1: pipeline flush (exception or branch cancel); aborts any operation.
- `start`, input, 1: EX holds a MATCH op; sampled only in IDLE.
- `src1`, input, 32: pattern operand; only bits [WINDOW-1:0] are used.
- `src2`, input, 32: searched operand.
- `stallreq`, output, 1: request to freeze IF/ID/EX.
- `busy`, output, 1: state is not IDLE.
- `done`, output, 1: one-cycle pulse; `result` is valid this cycle.
- `result`, output, 32: match offset or `NOMATCH_VAL`; holds its value until the next `done`.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, `pos`=0, operand registers=0, `result`=0, `done`=0, `busy`=0. `stallreq`=0 unless `start`=1.
- Internal registers: `pat[WINDOW-1:0]`, `shreg[31:0]`, `pos[4:0]`.
- States: IDLE, SCAN, DONE.
- IDLE:
  - `stallreq` = `start` & ~`flush` (combinational, so the issuing instruction stalls in its own cycle).
  - On `start` & ~`flush`: `pat` <= `src1[WINDOW-1:0]`, `shreg` <= `src2`, `pos` <= 0, go to SCAN.
- SCAN: `stallreq`=1, `busy`=1. Each cycle, compare `pat` with `shreg[WINDOW-1:0]`:
  - Equal: `result` <= `pos` (zero-extended), go to DONE.
  - Not equal and `pos`==POSITIONS-1: `result` <= `NOMATCH_VAL`, go to DONE.
  - Otherwise: `shreg` <= `shreg`>>1 (logical), `pos` <= `pos`+1, stay in SCAN.
- DONE: `done`=1, `stallreq`=0, `busy`=1. The pipeline advances and EX captures `result`. Next state is IDLE unconditionally. `start` is not sampled in DONE, so back-to-back MATCH ops restart from IDLE.
- Latency, with start accepted at cycle T:
  - Match at offset k: `done` at T+2+k. Minimum is T+2; maximum is T+26 (k=24).
  - No match: `done` at T+1+POSITIONS = T+26.
- Lowest matching offset wins. Multiple matches report the smallest k.
- Operands are latched at start; input changes during SCAN are ignored.
- `flush` from any state: next state is IDLE, `done` is suppressed, and `result` is unchanged. `stallreq` goes to 0 combinationally in the flush cycle. `flush` and `start` in the same cycle: `flush` wins and nothing is latched.
- `start` while busy is ignored; no queueing.
- Reset asserted mid-SCAN: immediate return to reset values. No `done` after deassertion.
- `result` is never X; it is registered and changes only on entry to DONE.

Test Plan:
- `src1`=0x0000_00AB, `src2`=0x0000_00AB, pulse `start` → `stallreq` high for cycles T,T+1; `done` at T+2; `result`=0.
- `src1`=0xFFFF_FFAB (upper bits ignored), `src2`=0x0000_AB00 → `done` at T+10; `result`=8; `stallreq` high T..T+9 and low at T+10.
- `src1`=0x5A, `src2`=0x5A00_0000 → `result`=24, `done` at T+26. Then `src1`=0x11, `src2`=0 → `result`=0xFFFF_FFFF, `done` at T+26.
- `src1`=0x03, `src2`=0x0000_0303 → `result`=0, lowest offset wins. Separately, `src1`=0, `src2`=0 → `result`=0.
- Start a no-match search, assert `flush` at T+5 → IDLE at T+6, no `done` pulse, `result` holds its previous value. Start and flush in the same cycle → `busy` stays 0.
- Assert `resetn`=0 at T+3 of a search → `busy`/`done`/`result` go to 0 immediately. After release, a new start gives correct latency. Changing `src2` mid-SCAN does not alter `result`.

Source files
------------

// File: rtl/ex_match_unit.sv
// Iterative byte-pattern search for the EX stage. It scans src2 one bit offset per cycle
// and reports the lowest offset whose WINDOW-bit slice equals src1[WINDOW-1:0].
module ex_match_unit #(
  parameter int          WINDOW      = 8,
  parameter int          POSITIONS   = 25,
  parameter logic [31:0] NOMATCH_VAL = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        start,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        stallreq,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  state_dbg
);

  // Handshake: the unit accepts start (with flush low) only in IDLE. stallreq is held high
  // from the accept cycle until the cycle before done. done is a one-cycle pulse. result
  // stays valid from that pulse until the next one. flush aborts in any state.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] LAST_POS = 5'(POSITIONS - 1);

  logic [1:0]        state, state_nxt;
  logic [WINDOW-1:0] pat;
  logic [31:0]       shreg;
  logic [4:0]        pos;
  logic              hit;
  logic              unused_src1;

  assign unused_src1 = ^src1[31:WINDOW];

  assign hit       = (pat == shreg[WINDOW-1:0]);
  assign state_dbg = state;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE) && !flush;

  // stallreq must go high in the issuing cycle itself, so it is decoded combinationally.
  always_comb begin
    stallreq = 1'b0;
    case (state)
      S_IDLE:  stallreq = start && !flush;
      S_SCAN:  stallreq = !flush;
      default: stallreq = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_SCAN;
        S_SCAN:  if (hit || pos == LAST_POS) state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pat    <= '0;
      shreg  <= '0;
      pos    <= '0;
      result <= '0;
    end else if (!flush) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pat   <= src1[WINDOW-1:0];
            shreg <= src2;
            pos   <= '0;
          end
        end
        S_SCAN: begin
          if (hit) begin
            result <= {27'd0, pos};
          end else if (pos == LAST_POS) begin
            result <= NOMATCH_VAL;
          end else begin
            shreg <= shreg >> 1;
            pos   <= pos + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_match_unit.sv
// Directed bench for ex_match_unit: checks latency, result, stall/busy shape, flush and
// reset. Outputs are sampled on the falling clock edge.
module tb_ex_match_unit;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        start;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        stallreq;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  ex_match_unit dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .start     (start),
    .src1      (src1),
    .src2      (src2),
    .stallreq  (stallreq),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issues one MATCH op. src2 is overwritten with mid_src2 on the second SCAN cycle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat,
                        input logic mid_change, input logic [31:0] mid_src2);
    int n;
    logic stall_ok;
    logic [31:0] exp;
    exp_q.push_back(exp_res);
    @(negedge clk);
    src1 = a; src2 = b; start = 1'b1;
    #1 check({tag, "_stall_T"}, 32'(stallreq), 32'd1);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    stall_ok = 1'b1;
    while (!done && n < 40) begin
      if (!stallreq || !busy) stall_ok = 1'b0;
      if (mid_change && n == 2) src2 = mid_src2;
      @(negedge clk);
      n++;
    end
    exp = exp_q.pop_front();
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_result"}, result, exp);
    check({tag, "_stall_during_scan"}, 32'(stall_ok), 32'd1);
    check({tag, "_stall_at_done"}, 32'(stallreq), 32'd0);
    @(negedge clk);
    check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int seen_done;
    resetn = 1'b0; flush = 1'b0; start = 1'b0; src1 = '0; src2 = '0;
    #12;
    check("reset_outputs", {29'd0, busy, done, stallreq}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op("pos0",    32'h0000_00AB, 32'h0000_00AB, 32'd0,        2,  1'b0, 32'd0);
    run_op("pos8",    32'hFFFF_FFAB, 32'h0000_AB00, 32'd8,        10, 1'b0, 32'd0);
    run_op("pos24",   32'h0000_005A, 32'h5A00_0000, 32'd24,       26, 1'b0, 32'd0);
    run_op("nomatch", 32'h0000_0011, 32'h0000_0000, 32'hFFFF_FFFF, 26, 1'b0, 32'd0);
    run_op("lowest",  32'h0000_0003, 32'h0000_0303, 32'd0,        2,  1'b0, 32'd0);
    run_op("zeros",   32'h0000_0000, 32'h0000_0000, 32'd0,        2,  1'b0, 32'd0);
    run_op("pos3",    32'h0000_00C5, 32'h0000_0628, 32'd3,        5,  1'b0, 32'd0);

    // flush during a no-match search at T+5 (result 3 from the previous op must hold)
    @(negedge clk);
    src1 = 32'h11; src2 = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    #1 check("flush_stall_comb", 32'(stallreq), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", 32'(busy), 32'd0);
    seen_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("flush_no_done", 32'(seen_done), 32'd0);
    check("flush_result_hold", result, 32'd3);

    // start and flush together
    @(negedge clk);
    src1 = 32'hAB; src2 = 32'hAB; start = 1'b1; flush = 1'b1;
    #1 check("start_flush_stall", 32'(stallreq), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", 32'(busy), 32'd0);
    check("start_flush_result", result, 32'd3);

    // reset at T+3 of a search
    @(negedge clk);
    src1 = 32'h11; src2 = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1 check("midreset_outputs", {30'd0, busy, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    seen_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("midreset_no_done", 32'(seen_done), 32'd0);

    // operands latched: src2 change mid-scan is ignored
    run_op("latched", 32'h0000_00AB, 32'h0000_AB00, 32'd8, 10, 1'b1, 32'h0000_00AB);

    // start while busy is ignored: the second start must not restart the search
    @(negedge clk);
    src1 = 32'h5A; src2 = 32'h5A00_0000; start = 1'b1;
    @(negedge clk);
    src1 = 32'hAB; src2 = 32'hAB;
    seen_done = 1;
    while (!done && seen_done < 40) begin
      @(negedge clk);
      seen_done++;
    end
    start = 1'b0;
    check("busy_start_latency", 32'(seen_done), 32'd26);
    check("busy_start_result", result, 32'd24);
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
